sound_sequencer: RTL
====================

Name: sound_sequencer

Overview:
- Upstream driver for the square-wave tone generator; converts single-cycle game event pulses into short fixed melodies.
- Outputs a note half-period (clk cycles per audio half-wave), a tone enable and a 2-bit sound type to the tone stage.
- Contains a step timebase, a small melody ROM, a priority/pre-emption arbiter and a 3-state FSM.

Parameters:
- STEP_CYCLES, 10000000: clk cycles per melody step (100 ms at 100 MHz); sims override to 10.
- GAP_CYCLES, 500000: silent cycles between consecutive notes of one melody (5 ms); sims override to 2; must be ≥1.
- CNT_W, 24: width of the step/gap counter; must hold max(STEP_CYCLES, GAP_CYCLES).

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  asynchronous, active-high reset.
- ev_press  input  1  1-cycle pulse: player button press.
- ev_score  input  1  1-cycle pulse: rope moved a position.
- ev_win  input  1  1-cycle pulse: game won.
- sound_type  output  2  0 = idle, 1 = press, 2 = score, 3 = win.
- half_period  output  19  tone half-period in clk cycles; 0 when idle.
- tone_on  output  1  high while a note sounds; low in gaps and idle.
- busy  output  1  high whenever FSM is not IDLE.
- done  output  1  1-cycle pulse when a melody completes naturally.

Behaviour:
- Reset: all outputs 0; FSM = IDLE; counters, note index and melody select = 0. Async assert; logic resumes on the first clk edge after deassert.
- Melody ROM (half_period values at 100 MHz, length in steps):
  - press: A5 56818 ×1.
  - score: A4 113636 ×1, C#5 90193 ×1, E5 75843 ×1.
  - win: C5 95556 ×1, E5 75843 ×1, G5 63776 ×1, C6 47778 ×4.
- Priority: win(3) > score(2) > press(1). Simultaneous pulses: highest wins, others dropped.
- FSM states:
  - IDLE: any event at edge N → PLAY at edge N with note 0 loaded. Outputs are registered: tone_on = 1, half_period, sound_type and busy are valid in the cycle after edge N.
  - PLAY: tone_on = 1. The counter runs len×STEP_CYCLES cycles.
    - If more notes remain: → GAP.
    - If last note: → IDLE, done = 1 for that one cycle, all other outputs return to 0 in the same cycle.
  - GAP: tone_on = 0; half_period and sound_type hold. After GAP_CYCLES cycles: → PLAY with the next note.
- Pre-emption: an event with priority strictly above the current sound_type, in PLAY or GAP, restarts immediately at note 0 of the new melody (same timing as from IDLE). No done pulse for the aborted melody.
- An equal- or lower-priority event while busy is dropped (see optional feature).
- An event in the same cycle as natural completion is treated as arriving in IDLE: it starts, and done still pulses.
- Counter is never compared against a value beyond STEP_CYCLES×4−1; no wrap-around is permitted.

Optional Feature:
- Macro: SOUND_PENDING_EN.
- Defined:
  - Adds a one-entry pending register that latches the highest equal/lower-priority event dropped while busy. A later, higher pending event overwrites a lower one.
  - On natural completion the pending melody starts on the next edge: done pulses, then one IDLE cycle, then PLAY. The pending entry is then cleared.
  - Pre-emption does not clear the pending entry. rst clears it.
- Undefined: such events are discarded; no pending storage exists.

Test Plan (STEP_CYCLES = 10, GAP_CYCLES = 2):
- Reset then single ev_press → sound_type = 1, half_period = 56818, tone_on high exactly 10 cycles, done pulses once, then all outputs 0.
- ev_score → notes 113636 / 90193 / 75843, each 10 cycles on with 2-cycle tone_on-low gaps; busy high 34 cycles; done once.
- ev_win → four notes, last note 47778 held 40 cycles; total busy 3×10 + 3×2 + 40 = 76 cycles.
- ev_score mid-note 2, then ev_win → win restarts at 95556 on the next cycle, no done for score. Also: ev_press during win → ignored, win timing unchanged.
- ev_press and ev_win in the same cycle → sound_type = 3 only. rst asserted mid-melody → outputs 0 asynchronously; the first post-reset event plays normally.
- With SOUND_PENDING_EN: ev_press during score → score completes with done, press starts 2 cycles later (one IDLE cycle between). Without the macro: no press plays.

Source files
------------

// File: rtl/sound_sequencer.sv
// Game sound sequencer: turns event pulses into short melodies for the tone stage.
// Optional SOUND_PENDING_EN keeps one dropped event and plays it after the current melody.
module sound_sequencer #(
    parameter int unsigned STEP_CYCLES = 10000000,
    parameter int unsigned GAP_CYCLES  = 500000,
    parameter int unsigned CNT_W       = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ev_press,
    input  logic        ev_score,
    input  logic        ev_win,
    output logic [1:0]  sound_type,
    output logic [18:0] half_period,
    output logic        tone_on,
    output logic        busy,
    output logic        done
);

    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       note_idx;
    logic [1:0]       step_idx;

    logic [1:0] ev_prio;
    logic [1:0] cand;
    logic [1:0] start_mel;
    logic       start_now;
    logic       step_end;
    logic       finishing;

    // Melody ROM, indexed by sound type and note number.
    function automatic logic [18:0] rom_hp(input logic [1:0] mel, input logic [1:0] idx);
        case ({mel, idx})
            4'b01_00: rom_hp = 19'd56818;
            4'b10_00: rom_hp = 19'd113636;
            4'b10_01: rom_hp = 19'd90193;
            4'b10_10: rom_hp = 19'd75843;
            4'b11_00: rom_hp = 19'd95556;
            4'b11_01: rom_hp = 19'd75843;
            4'b11_10: rom_hp = 19'd63776;
            4'b11_11: rom_hp = 19'd47778;
            default:  rom_hp = 19'd0;
        endcase
    endfunction

    // Note length is counted in whole steps so the counter never exceeds STEP_CYCLES.
    function automatic logic [1:0] last_step(input logic [1:0] mel, input logic [1:0] idx);
        last_step = (mel == 2'd3 && idx == 2'd3) ? 2'd3 : 2'd0;
    endfunction

    function automatic logic [1:0] last_note(input logic [1:0] mel);
        case (mel)
            2'd2:    last_note = 2'd2;
            2'd3:    last_note = 2'd3;
            default: last_note = 2'd0;
        endcase
    endfunction

    always_comb begin
        if (ev_win)        ev_prio = 2'd3;
        else if (ev_score) ev_prio = 2'd2;
        else if (ev_press) ev_prio = 2'd1;
        else               ev_prio = 2'd0;
    end

`ifdef SOUND_PENDING_EN
    logic [1:0] pending;
    always_comb cand = (pending > ev_prio) ? pending : ev_prio;
`else
    always_comb cand = ev_prio;
`endif

    always_comb begin
        // NOTE: every combinational output gets a value on every path so no latch is inferred.
        step_end  = (cnt == STEP_LAST) && (step_idx == last_step(sound_type, note_idx));
        finishing = (state == PLAY) && step_end && (note_idx == last_note(sound_type));
        if (state == IDLE) begin
            start_now = (cand != 2'd0);
            start_mel = cand;
        end else begin
            // Higher priority pre-empts; any event at natural completion starts as if idle.
            start_now = (ev_prio > sound_type) || (finishing && ev_prio != 2'd0);
            start_mel = ev_prio;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            note_idx    <= 2'd0;
            step_idx    <= 2'd0;
            sound_type  <= 2'd0;
            half_period <= 19'd0;
            tone_on     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef SOUND_PENDING_EN
            pending     <= 2'd0;
`endif
        end else begin
            // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
            done <= finishing;
            if (start_now) begin
                state       <= PLAY;
                cnt         <= '0;
                note_idx    <= 2'd0;
                step_idx    <= 2'd0;
                sound_type  <= start_mel;
                half_period <= rom_hp(start_mel, 2'd0);
                tone_on     <= 1'b1;
                busy        <= 1'b1;
            end else begin
                case (state)
                    PLAY: begin
                        if (cnt == STEP_LAST) begin
                            cnt <= '0;
                            if (!step_end) begin
                                step_idx <= step_idx + 2'd1;
                            end else if (!finishing) begin
                                state    <= GAP;
                                tone_on  <= 1'b0;
                                note_idx <= note_idx + 2'd1;
                                step_idx <= 2'd0;
                            end else begin
                                state       <= IDLE;
                                note_idx    <= 2'd0;
                                step_idx    <= 2'd0;
                                sound_type  <= 2'd0;
                                half_period <= 19'd0;
                                tone_on     <= 1'b0;
                                busy        <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    GAP: begin
                        if (cnt == GAP_LAST) begin
                            cnt         <= '0;
                            state       <= PLAY;
                            tone_on     <= 1'b1;
                            half_period <= rom_hp(sound_type, note_idx);
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
`ifdef SOUND_PENDING_EN
            // Pending starts only from IDLE; dropped events while busy keep the highest one.
            if (state == IDLE && start_now && start_mel == pending) begin
                pending <= 2'd0;
            end else if (state != IDLE && ev_prio != 2'd0 && ev_prio <= sound_type &&
                         !finishing && ev_prio > pending) begin
                pending <= ev_prio;
            end
`endif
        end
    end

endmodule
